// File: rtl/byte_repack_fifo.sv
// Byte-granular FIFO: accepts 1..LANES bytes per write and returns 1..LANES bytes per read.
// Storage is a shift register with the oldest byte at position 0.
module byte_repack_fifo #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 40,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW = $clog2(LANES + 1),
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*LANES-1:0]   din_i,
    input  logic [CW-1:0]        din_cnt_i,
    input  logic                 wr_en_i,
    output logic                 wr_ready_o,
    input  logic [CW-1:0]        rd_cnt_i,
    input  logic                 rd_en_i,
    output logic                 rd_ready_o,
    output logic [8*LANES-1:0]   dout_o,
    output logic                 dout_valid_o,
    output logic [LW-1:0]        level_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 ovf_err_o,
    output logic                 udf_err_o
);

    localparam logic [LW:0]   DepthExt = (LW + 1)'(DEPTH);
    localparam logic [CW-1:0] LanesCw  = CW'(LANES);

    logic [DEPTH-1:0][7:0] mem_q, mem_d;
    logic [LW-1:0]         level_q, level_d;
    logic [8*LANES-1:0]    dout_q, dout_d;
    logic                  dout_valid_q;
    logic                  ovf_q, udf_q;

    logic                  rd_legal, wr_legal, rd_acc, wr_acc;
    logic [LW:0]           lvl_ext, rd_n, wr_n, free_n, base;
    logic [LANES-1:0][7:0] wr_bytes;

    assign lvl_ext    = {1'b0, level_q};
    assign rd_legal   = (rd_cnt_i != '0) && (rd_cnt_i <= LanesCw);
    assign rd_ready_o = rd_legal && (lvl_ext >= (LW + 1)'(rd_cnt_i));
    assign rd_acc     = rd_en_i && rd_ready_o;
    assign rd_n       = rd_acc ? (LW + 1)'(rd_cnt_i) : '0;

    // Space freed by a same-cycle accepted read counts toward the write.
    assign free_n     = DepthExt - lvl_ext + rd_n;
    assign wr_legal   = (din_cnt_i != '0) && (din_cnt_i <= LanesCw);
    assign wr_ready_o = wr_legal && (free_n >= (LW + 1)'(din_cnt_i));
    assign wr_acc     = wr_en_i && wr_ready_o;
    assign wr_n       = wr_acc ? (LW + 1)'(din_cnt_i) : '0;

    assign base       = lvl_ext - rd_n;
    assign level_d    = LW'(lvl_ext - rd_n + wr_n);

    always_comb begin
        wr_bytes = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (MSB_FIRST) begin
                wr_bytes[k] = din_i[8*(LANES-1-k) +: 8];
            end else begin
                wr_bytes[k] = din_i[8*k +: 8];
            end
        end
    end

    // Shift out the read bytes, then append the write at the post-read tail.
    always_comb begin
        mem_d = '0;
        for (int unsigned r = 0; r <= LANES; r++) begin
            if (rd_n == (LW + 1)'(r)) begin
                for (int unsigned i = 0; i + r < DEPTH; i++) begin
                    mem_d[i] = mem_q[i+r];
                end
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (((LW + 1)'(k) < wr_n) && ((LW + 1)'(i) == base + (LW + 1)'(k))) begin
                    mem_d[i] = wr_bytes[k];
                end
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                if ((LW + 1)'(k) < rd_n) begin
                    if (MSB_FIRST) begin
                        dout_d[8*(LANES-1-k) +: 8] = mem_q[k];
                    end else begin
                        dout_d[8*k +: 8] = mem_q[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q        <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= rd_acc;
            ovf_q        <= ovf_q | (wr_en_i && (din_cnt_i != '0) && !wr_ready_o);
            udf_q        <= udf_q | (rd_en_i && (rd_cnt_i != '0) && !rd_ready_o);
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign level_o      = level_q;
    assign full_o       = (level_q == LW'(DEPTH));
    assign empty_o      = (level_q == '0);
    assign ovf_err_o    = ovf_q;
    assign udf_err_o    = udf_q;

endmodule

// File: tb/tb_byte_repack_fifo.sv
// Bench for byte_repack_fifo: directed table, corner sequences, and random traffic
// compared against a byte-queue reference model.
module tb_byte_repack_fifo;

    localparam int unsigned LANES = 4;
    localparam int unsigned DEPTH = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic [2:0]  din_cnt = '0;
    logic        wr_en = 1'b0;
    logic        wr_ready;
    logic [2:0]  rd_cnt = '0;
    logic        rd_en = 1'b0;
    logic        rd_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic [5:0]  level;
    logic        full, empty, ovf_err, udf_err;

    logic [31:0] b_din = '0;
    logic [2:0]  b_din_cnt = '0;
    logic        b_wr_en = 1'b0;
    logic        b_wr_ready;
    logic [2:0]  b_rd_cnt = '0;
    logic        b_rd_en = 1'b0;
    logic        b_rd_ready;
    logic [31:0] b_dout;
    logic        b_dout_valid;
    logic [5:0]  b_level;
    logic        b_full, b_empty, b_ovf_err, b_udf_err;

    always #5 clk = ~clk;

    byte_repack_fifo #(.LANES(LANES), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_i(din), .din_cnt_i(din_cnt), .wr_en_i(wr_en),
        .wr_ready_o(wr_ready), .rd_cnt_i(rd_cnt), .rd_en_i(rd_en), .rd_ready_o(rd_ready),
        .dout_o(dout), .dout_valid_o(dout_valid), .level_o(level), .full_o(full),
        .empty_o(empty), .ovf_err_o(ovf_err), .udf_err_o(udf_err)
    );

    byte_repack_fifo #(.LANES(LANES), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .din_i(b_din), .din_cnt_i(b_din_cnt), .wr_en_i(b_wr_en),
        .wr_ready_o(b_wr_ready), .rd_cnt_i(b_rd_cnt), .rd_en_i(b_rd_en),
        .rd_ready_o(b_rd_ready), .dout_o(b_dout), .dout_valid_o(b_dout_valid),
        .level_o(b_level), .full_o(b_full), .empty_o(b_empty), .ovf_err_o(b_ovf_err),
        .udf_err_o(b_udf_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned m_q[$];
    logic [31:0]  m_dout;
    bit           m_valid, m_ovf, m_udf;

    typedef struct {
        bit          re;
        logic [2:0]  rc;
        bit          we;
        logic [31:0] d;
        logic [2:0]  dc;
        int          lvl;
        logic [31:0] dout;
        bit          vld;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle on the main DUT; the model decides acceptance from the byte count rules.
    task automatic step(input bit re, input logic [2:0] rc, input bit we,
                        input logic [31:0] d, input logic [2:0] dc);
        bit rd_rdy, wr_rdy, rd_ok, wr_ok;
        int fr;
        rd_en = re; rd_cnt = rc; wr_en = we; din = d; din_cnt = dc;
        #1;
        rd_rdy = (rc >= 1) && (rc <= 3'(LANES)) && (m_q.size() >= int'(rc));
        rd_ok  = re && rd_rdy;
        fr     = int'(DEPTH) - m_q.size() + (rd_ok ? int'(rc) : 0);
        wr_rdy = (dc >= 1) && (dc <= 3'(LANES)) && (fr >= int'(dc));
        wr_ok  = we && wr_rdy;
        check("rd_ready", 64'(rd_ready), 64'(rd_rdy));
        check("wr_ready", 64'(wr_ready), 64'(wr_rdy));
        if (re && rc != 0 && !rd_ok) m_udf = 1'b1;
        if (we && dc != 0 && !wr_ok) m_ovf = 1'b1;
        m_valid = rd_ok;
        if (rd_ok) begin
            m_dout = '0;
            for (int k = 0; k < int'(rc); k++) m_dout[31-8*k -: 8] = m_q.pop_front();
        end
        if (wr_ok) begin
            for (int k = 0; k < int'(dc); k++) m_q.push_back(d[31-8*k -: 8]);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        check("level", 64'(level), 64'(m_q.size()));
        check("dout", 64'(dout), 64'(m_dout));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("udf_err", 64'(udf_err), 64'(m_udf));
        check("full", 64'(full), 64'(m_q.size() == int'(DEPTH)));
        check("empty", 64'(empty), 64'(m_q.size() == 0));
    endtask

    // Reset with both request strobes held high; reset must win.
    task automatic do_reset();
        rst_n = 1'b0;
        rd_en = 1'b1; rd_cnt = 3'd1; wr_en = 1'b1; din = '1; din_cnt = 3'd4;
        b_rd_en = 1'b1; b_rd_cnt = 3'd1; b_wr_en = 1'b1; b_din = '1; b_din_cnt = 3'd4;
        @(posedge clk);
        #1;
        check("rst level", 64'(level), 64'd0);
        check("rst dout", 64'(dout), 64'd0);
        check("rst dout_valid", 64'(dout_valid), 64'd0);
        check("rst ovf_err", 64'(ovf_err), 64'd0);
        check("rst udf_err", 64'(udf_err), 64'd0);
        check("rst empty", 64'(empty), 64'd1);
        check("rst b_level", 64'(b_level), 64'd0);
        rst_n = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; b_rd_en = 1'b0; b_wr_en = 1'b0;
        m_q.delete();
        m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //         re    rc    we    din           dc    lvl dout          vld ovf udf
        tv[0]  = '{1'b1, 3'd1, 1'b0, 32'h0,        3'd0, 0,  32'h00000000, 1, 0, 1};
        tv[0].vld = 1'b0;
        tv[1]  = '{1'b0, 3'd0, 1'b1, 32'hAABBCCDD, 3'd3, 3,  32'h00000000, 0, 0, 1};
        tv[2]  = '{1'b1, 3'd2, 1'b0, 32'h0,        3'd0, 1,  32'hAABB0000, 1, 0, 1};
        tv[3]  = '{1'b0, 3'd0, 1'b0, 32'h0,        3'd0, 1,  32'hAABB0000, 0, 0, 1};
        tv[4]  = '{1'b1, 3'd2, 1'b1, 32'h22000000, 3'd1, 2,  32'hAABB0000, 0, 0, 1};
        tv[5]  = '{1'b1, 3'd0, 1'b1, 32'h12345678, 3'd0, 2,  32'hAABB0000, 0, 0, 1};
        tv[6]  = '{1'b1, 3'd2, 1'b0, 32'h0,        3'd0, 0,  32'hCC220000, 1, 0, 1};
        tv[7]  = '{1'b0, 3'd0, 1'b1, 32'h11223344, 3'd4, 4,  32'hCC220000, 0, 0, 1};
        tv[8]  = '{1'b0, 3'd0, 1'b1, 32'h55667788, 3'd4, 8,  32'hCC220000, 0, 0, 1};
        tv[9]  = '{1'b1, 3'd5, 1'b0, 32'h0,        3'd0, 8,  32'hCC220000, 0, 0, 1};
        tv[10] = '{1'b0, 3'd0, 1'b1, 32'hCAFEF00D, 3'd5, 8,  32'hCC220000, 0, 1, 1};
        tv[11] = '{1'b1, 3'd4, 1'b0, 32'h0,        3'd0, 4,  32'h11223344, 1, 1, 1};
        tv[12] = '{1'b0, 3'd0, 1'b1, 32'h99FFFFFF, 3'd1, 5,  32'h11223344, 0, 1, 1};
        tv[13] = '{1'b1, 3'd4, 1'b0, 32'h0,        3'd0, 1,  32'h55667788, 1, 1, 1};
        tv[14] = '{1'b1, 3'd1, 1'b0, 32'h0,        3'd0, 0,  32'h99000000, 1, 1, 1};

        @(posedge clk);
        #1;
        do_reset();

        // Little-endian lane order on the second instance.
        b_wr_en = 1'b1; b_din = 32'hDDCCBBAA; b_din_cnt = 3'd3;
        @(posedge clk);
        #1;
        b_wr_en = 1'b0;
        check("lsb level after write", 64'(b_level), 64'd3);
        b_rd_en = 1'b1; b_rd_cnt = 3'd2;
        @(posedge clk);
        #1;
        b_rd_en = 1'b0;
        check("lsb dout", 64'(b_dout), 64'h0000BBAA);
        check("lsb dout_valid", 64'(b_dout_valid), 64'd1);
        check("lsb level after read", 64'(b_level), 64'd1);

        for (int i = 0; i < 15; i++) begin
            step(tv[i].re, tv[i].rc, tv[i].we, tv[i].d, tv[i].dc);
            check($sformatf("tv%0d level", i), 64'(level), 64'(tv[i].lvl));
            check($sformatf("tv%0d dout", i), 64'(dout), 64'(tv[i].dout));
            check($sformatf("tv%0d dout_valid", i), 64'(dout_valid), 64'(tv[i].vld));
            check($sformatf("tv%0d ovf_err", i), 64'(ovf_err), 64'(tv[i].ovf));
            check($sformatf("tv%0d udf_err", i), 64'(udf_err), 64'(tv[i].udf));
        end

        // Fill to capacity, overflow, then simultaneous read+write at full.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 1'b1, 32'h01010101 * (i + 1), 3'd4);
        check("fill level", 64'(level), 64'd40);
        check("fill full", 64'(full), 64'd1);
        din_cnt = 3'd4;
        #1;
        check("fill wr_ready", 64'(wr_ready), 64'd0);
        step(1'b0, 3'd0, 1'b1, 32'hEEEEEEEE, 3'd4);
        check("overflow ovf_err", 64'(ovf_err), 64'd1);
        check("overflow level", 64'(level), 64'd40);
        step(1'b1, 3'd4, 1'b1, 32'hDEADBEEF, 3'd4);
        check("full rw level", 64'(level), 64'd40);
        check("full rw dout", 64'(dout), 64'h01010101);
        check("full rw dout_valid", 64'(dout_valid), 64'd1);

        // Mid-stream reset discards everything.
        do_reset();
        step(1'b1, 3'd1, 1'b0, 32'h0, 3'd0);
        check("post-reset read udf_err", 64'(udf_err), 64'd1);
        check("post-reset read dout_valid", 64'(dout_valid), 64'd0);

        do_reset();
        for (int it = 0; it < 600; it++) begin
            if (it == 300) do_reset();
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
